// File: rtl/mod10_cascade_ctrl.sv
// Run controller for a cascade of DIGITS mod-10 (BCD) counter stages.
// Latches a BCD target on start, drives the ripple enables and stops the
// cascade exactly at the target. Supports pause and abort.
module mod10_cascade_ctrl #(
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  start_in,
  input  logic [4*DIGITS-1:0]   target_in,
  input  logic                  pause_in,
  input  logic                  abort_in,
  output logic [4*DIGITS-1:0]   count_out,
  output logic [DIGITS-1:0]     digit_en_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  err_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [4*DIGITS-1:0] count_q;
  logic [4*DIGITS-1:0] count_nxt;
  logic [4*DIGITS-1:0] count_inc;
  logic [4*DIGITS-1:0] target_q;
  logic [4*DIGITS-1:0] target_nxt;
  logic [DIGITS-1:0]   digit_en;
  logic                err_q;
  logic                err_nxt;
  logic                target_ok;

  // A start target is usable only if every nibble is a valid BCD digit
  always_comb begin
    target_ok = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (target_in[4*k +: 4] > 4'd9) begin
        target_ok = 1'b0;
      end
    end
  end

  // Ripple enable chain; a running carry variable keeps the chain acyclic
  always_comb begin
    logic carry;
    carry = (state == RUN) && !pause_in && !abort_in;
    digit_en = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (k > 0) begin
        carry = carry && (count_q[4*(k-1) +: 4] == 4'd9);
      end
      digit_en[k] = carry;
    end
  end

  // Incremented cascade value: enabled digits step mod 10, others hold
  always_comb begin
    count_inc = count_q;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (digit_en[k]) begin
        if (count_q[4*k +: 4] == 4'd9) begin
          count_inc[4*k +: 4] = 4'd0;
        end else begin
          count_inc[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort outranks pause, pause outranks counting
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start_in && target_ok) begin
          state_nxt = (target_in == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort_in) begin
          state_nxt = IDLE;
        end else if (pause_in) begin
          state_nxt = PAUSE;
        end else if (count_inc == target_q) begin
          state_nxt = DONE;
        end
      end
      PAUSE: begin
        if (abort_in) begin
          state_nxt = IDLE;
        end else if (!pause_in) begin
          state_nxt = RUN;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath next values: count, latched target and start-error flag
  always_comb begin
    count_nxt  = count_q;
    target_nxt = target_q;
    err_nxt    = 1'b0;
    if (state == IDLE && start_in) begin
      if (target_ok) begin
        count_nxt  = '0;
        target_nxt = target_in;
      end else begin
        err_nxt = 1'b1;
      end
    end else if (state == RUN) begin
      count_nxt = count_inc;
    end
  end

  // Datapath registers
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      count_q  <= '0;
      target_q <= '0;
      err_q    <= 1'b0;
    end else begin
      count_q  <= count_nxt;
      target_q <= target_nxt;
      err_q    <= err_nxt;
    end
  end

  // Output decode from registered state and flags
  always_comb begin
    count_out    = count_q;
    digit_en_out = digit_en;
    busy_out     = (state == RUN) || (state == PAUSE);
    done_out     = (state == DONE);
    err_out      = err_q;
  end

endmodule

// File: tb/tb_mod10_cascade_ctrl.sv
// Self-checking bench for mod10_cascade_ctrl with DIGITS=2.
// Expected count sequences are queued when a run is started and popped
// once per clock as the DUT advances.
module tb_mod10_cascade_ctrl;

  logic       clk_in;
  logic       reset_in;
  logic       start_in;
  logic [7:0] target_in;
  logic       pause_in;
  logic       abort_in;
  logic [7:0] count_out;
  logic [1:0] digit_en_out;
  logic       busy_out;
  logic       done_out;
  logic       err_out;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [7:0]  exp_q[$];

  mod10_cascade_ctrl #(.DIGITS(2)) dut (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .start_in     (start_in),
    .target_in    (target_in),
    .pause_in     (pause_in),
    .abort_in     (abort_in),
    .count_out    (count_out),
    .digit_en_out (digit_en_out),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .err_out      (err_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 10);
    ones = 4'(v % 10);
    return {tens, ones};
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    reset_in  = 1'b1;
    start_in  = 1'b0;
    target_in = 8'h00;
    pause_in  = 1'b0;
    abort_in  = 1'b0;
    #2 reset_in = 1'b0;
    tick();
    tick();
    n_cmp++; if (count_out !== 8'h00) begin n_bad++; $display("FAIL reset_count: got %h want 00", count_out); end
    n_cmp++; if (busy_out !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_out); end
    n_cmp++; if (done_out !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done_out); end
    n_cmp++; if (err_out !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_out); end
    n_cmp++; if (digit_en_out !== 2'b00) begin n_bad++; $display("FAIL reset_en: got %b want 00", digit_en_out); end
    #3 reset_in = 1'b1;
    tick();
  endtask

  // Unpaused run from IDLE to target t (decimal), then one IDLE cycle
  task automatic test_plain_run(input int t);
    logic [7:0] e;
    logic [1:0] exp_en;
    start_in  = 1'b1;
    target_in = to_bcd(t);
    for (int n = 1; n <= t; n++) exp_q.push_back(to_bcd(n));
    tick();
    start_in = 1'b0;
    n_cmp++; if (count_out !== 8'h00) begin n_bad++; $display("FAIL run%0d_clear: got %h want 00", t, count_out); end
    n_cmp++; if (busy_out !== 1'b1) begin n_bad++; $display("FAIL run%0d_busy0: got %b want 1", t, busy_out); end
    for (int n = 1; n <= t; n++) begin
      tick();
      e = exp_q.pop_front();
      exp_en = (n < t) ? ((n % 10 == 9) ? 2'b11 : 2'b01) : 2'b00;
      n_cmp++; if (count_out !== e) begin n_bad++; $display("FAIL run%0d_count@%0d: got %h want %h", t, n, count_out, e); end
      n_cmp++; if (done_out !== 1'(n == t)) begin n_bad++; $display("FAIL run%0d_done@%0d: got %b want %b", t, n, done_out, n == t); end
      n_cmp++; if (busy_out !== 1'(n < t)) begin n_bad++; $display("FAIL run%0d_busy@%0d: got %b want %b", t, n, busy_out, n < t); end
      n_cmp++; if (digit_en_out !== exp_en) begin n_bad++; $display("FAIL run%0d_en@%0d: got %b want %b", t, n, digit_en_out, exp_en); end
    end
    for (int n = 0; n < 2; n++) begin
      tick();
      n_cmp++; if (count_out !== to_bcd(t)) begin n_bad++; $display("FAIL run%0d_hold: got %h want %h", t, count_out, to_bcd(t)); end
      n_cmp++; if (done_out !== 1'b0 || busy_out !== 1'b0) begin n_bad++; $display("FAIL run%0d_idle: got done=%b busy=%b want 0 0", t, done_out, busy_out); end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL run%0d_queue: got %0d left want 0", t, exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_invalid_target();
    logic [7:0] bad [2];
    logic [7:0] held;
    bad[0] = 8'h1A;
    bad[1] = 8'hA0;
    for (int i = 0; i < 2; i++) begin
      held = count_out;
      start_in  = 1'b1;
      target_in = bad[i];
      tick();
      start_in = 1'b0;
      n_cmp++; if (err_out !== 1'b1) begin n_bad++; $display("FAIL err_pulse_%h: got %b want 1", bad[i], err_out); end
      n_cmp++; if (busy_out !== 1'b0) begin n_bad++; $display("FAIL err_busy_%h: got %b want 0", bad[i], busy_out); end
      n_cmp++; if (count_out !== held) begin n_bad++; $display("FAIL err_count_%h: got %h want %h", bad[i], count_out, held); end
      tick();
      n_cmp++; if (err_out !== 1'b0) begin n_bad++; $display("FAIL err_clear_%h: got %b want 0", bad[i], err_out); end
      n_cmp++; if (busy_out !== 1'b0 || done_out !== 1'b0) begin n_bad++; $display("FAIL err_idle_%h: got busy=%b done=%b want 0 0", bad[i], busy_out, done_out); end
    end
  endtask

  task automatic test_zero_target();
    start_in  = 1'b1;
    target_in = 8'h00;
    tick();
    start_in = 1'b0;
    n_cmp++; if (done_out !== 1'b1) begin n_bad++; $display("FAIL zero_done: got %b want 1", done_out); end
    n_cmp++; if (count_out !== 8'h00) begin n_bad++; $display("FAIL zero_count: got %h want 00", count_out); end
    n_cmp++; if (busy_out !== 1'b0) begin n_bad++; $display("FAIL zero_busy: got %b want 0", busy_out); end
    tick();
    n_cmp++; if (done_out !== 1'b0) begin n_bad++; $display("FAIL zero_done_end: got %b want 0", done_out); end
  endtask

  // Target 20, pause held for 5 edges from count 07; done lands 6 cycles late
  task automatic test_pause();
    logic [7:0] e;
    int         v;
    start_in  = 1'b1;
    target_in = 8'h20;
    for (int c = 1; c <= 26; c++) begin
      v = (c <= 7) ? c : ((c <= 13) ? 7 : c - 6);
      exp_q.push_back(to_bcd(v));
    end
    tick();
    start_in = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      tick();
      e = exp_q.pop_front();
      if (c == 7)  pause_in = 1'b1;
      if (c == 12) pause_in = 1'b0;
      n_cmp++; if (count_out !== e) begin n_bad++; $display("FAIL pause_count@%0d: got %h want %h", c, count_out, e); end
      n_cmp++; if (done_out !== 1'(c == 26)) begin n_bad++; $display("FAIL pause_done@%0d: got %b want %b", c, done_out, c == 26); end
      if (c >= 8 && c <= 12) begin
        n_cmp++; if (busy_out !== 1'b1 || digit_en_out !== 2'b00) begin n_bad++; $display("FAIL pause_hold@%0d: got busy=%b en=%b want 1 00", c, busy_out, digit_en_out); end
      end
    end
    tick();
    n_cmp++; if (busy_out !== 1'b0 || count_out !== 8'h20) begin n_bad++; $display("FAIL pause_end: got busy=%b count=%h want 0 20", busy_out, count_out); end
    exp_q.delete();
  endtask

  task automatic test_abort();
    start_in  = 1'b1;
    target_in = 8'h50;
    tick();
    start_in = 1'b0;
    for (int c = 1; c <= 23; c++) tick();
    n_cmp++; if (count_out !== 8'h23) begin n_bad++; $display("FAIL abort_pre: got %h want 23", count_out); end
    abort_in = 1'b1;
    tick();
    abort_in = 1'b0;
    n_cmp++; if (count_out !== 8'h23) begin n_bad++; $display("FAIL abort_count: got %h want 23", count_out); end
    n_cmp++; if (busy_out !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy_out); end
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (done_out !== 1'b0) begin n_bad++; $display("FAIL abort_nodone@%0d: got %b want 0", c, done_out); end
      tick();
    end
    test_plain_run(3);
  endtask

  task automatic test_async_reset();
    start_in  = 1'b1;
    target_in = 8'h40;
    tick();
    start_in = 1'b0;
    for (int c = 1; c <= 31; c++) tick();
    n_cmp++; if (count_out !== 8'h31) begin n_bad++; $display("FAIL areset_pre: got %h want 31", count_out); end
    #2 reset_in = 1'b0;
    #1;
    n_cmp++; if (count_out !== 8'h00) begin n_bad++; $display("FAIL areset_count: got %h want 00", count_out); end
    n_cmp++; if (busy_out !== 1'b0 || done_out !== 1'b0 || err_out !== 1'b0) begin n_bad++; $display("FAIL areset_flags: got busy=%b done=%b err=%b want 0 0 0", busy_out, done_out, err_out); end
    n_cmp++; if (digit_en_out !== 2'b00) begin n_bad++; $display("FAIL areset_en: got %b want 00", digit_en_out); end
    tick();
    #3 reset_in = 1'b1;
    tick();
    n_cmp++; if (count_out !== 8'h00 || busy_out !== 1'b0) begin n_bad++; $display("FAIL areset_release: got count=%h busy=%b want 00 0", count_out, busy_out); end
    test_plain_run(2);
  endtask

  initial begin
    test_reset();
    test_plain_run(12);
    test_plain_run(99);
    test_invalid_target();
    test_zero_target();
    test_pause();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mod10_cascade_ctrl.md
Name: mod10_cascade_ctrl

Overview:
- Run controller for a cascade of DIGITS mod-10 (BCD) counter stages.
- Accepts a start command with a BCD target and sequences the per-digit enables and carries.
- Stops the cascade exactly at the target; supports pause and abort.
- Sits between the host control logic and the decade-counter datapath. It owns the digit registers so the whole cascade is checked as one unit.

Parameters:
- DIGITS, 2, number of cascaded mod-10 stages (1..8).

Ports:
- clk_in  input  1  clock; all state changes on the rising edge
- reset_in  input  1  asynchronous, active-low reset; 0 clears all state immediately
- start_in  input  1  start request; sampled only in IDLE
- target_in  input  4*DIGITS  BCD target count, nibble k = digit k (k=0 is LSD); latched on accepted start
- pause_in  input  1  level; freezes counting while high
- abort_in  input  1  level; cancels a run
- count_out  output  4*DIGITS  current BCD count, registered
- digit_en_out  output  DIGITS  per-digit increment enables for the current cycle
- busy_out  output  1  high in RUN or PAUSE
- done_out  output  1  one-cycle pulse: target reached
- err_out  output  1  one-cycle pulse: start rejected

Behaviour:
- Reset values (reset_in=0, asynchronous): state=IDLE, count_out=0, latched target=0, busy_out=0, done_out=0, err_out=0. digit_en_out=0 by decode.
- FSM states: IDLE, RUN, PAUSE, DONE.
- IDLE, start_in=1, target valid (every nibble <=9):
  - next edge: count_out<=0 and the target is latched;
  - state goes to RUN if target!=0, otherwise to DONE.
- IDLE, start_in=1, any nibble >9: err_out=1 for the following cycle; state stays IDLE; count_out unchanged.
- start_in outside IDLE: ignored, no error.
- RUN, priority abort_in > pause_in > count:
  - abort_in=1: next state IDLE; count_out holds; no done_out.
  - pause_in=1: next state PAUSE; no increment on that edge.
  - otherwise: increment the cascade; if the incremented value equals the target, next state DONE.
- digit_en_out, combinational:
  - digit_en_out[0] = (state==RUN) & !pause_in & !abort_in;
  - digit_en_out[k] = digit_en_out[k-1] & (digit[k-1]==9).
- Digit update: an enabled digit goes d -> d+1, and 9 -> 0. A disabled digit holds. Digit values are never >9.
- PAUSE transitions:
  - abort_in=1 -> IDLE;
  - pause_in=0 -> RUN, no increment on that edge (resume costs 1 cycle);
  - otherwise stay in PAUSE. count_out holds throughout.
- DONE: done_out=1 while in DONE, exactly one cycle, then unconditionally IDLE. count_out equals the target and holds until the next accepted start.
- done_out, err_out and busy_out are decoded from registered state/flags, so they are glitch-free.
- Latency: start accepted at edge 0 with target T (decimal value of the BCD digits), no pause:
  - count_out = n after edge n;
  - state DONE after edge T; done_out high in cycle T;
  - IDLE after edge T+1.
- Each pause cycle in RUN, and each resume, adds one cycle to the run.
- Overflow is impossible: the maximum target (all 9s) stops before the cascade wraps.
- Reset mid-run: immediate return to reset values; the latched target is lost.

Test Plan:
- DIGITS=2, target 0x12, start pulse: count_out steps 00,01..09,10,11,12 on edges 1..12, the 09->10 step with digit_en_out=2'b11; done_out high in cycle 12 only; busy_out falls after edge 12; count_out holds 0x12.
- Target 0x99: exact stop at 0x99 after 99 RUN edges; no wrap to 0x00; done_out a single pulse.
- Target 0x1A and then 0xA0: err_out pulses 1 cycle each; state stays IDLE; busy_out=0; count_out unchanged. Target 0x00: done_out pulse on the cycle after the start edge; count_out=0x00.
- Target 0x20, pause_in high for 5 cycles starting at count 0x07: count_out holds 0x07 while paused; one resume cycle adds no increment; done_out arrives 6 cycles later than in the unpaused run.
- Target 0x50, abort_in at count 0x23: IDLE next edge; count_out=0x23; no done_out. A new start with target 0x03 then clears to 0 and completes normally.
- reset_in driven low asynchronously (between edges) at count 0x31: all outputs reach their reset values immediately, without waiting for a clock edge. After release, start_in with target 0x02 completes in 2 cycles.
